// File: rtl/serial_key_reader_if.sv
// serial_key_reader_if: controller request/result and key bus signals of the serial-key reader
interface serial_key_reader_if #(
  parameter int NUM_UNLOCK = 4,
  parameter int DATA_BITS = 16
);
  logic start;
  logic abort;
  logic [4*NUM_UNLOCK-1:0] unlock_code;
  logic sdrd;
  logic sser_n;
  logic ba13;
  logic ba12;
  logic [3:0] ba_nib;
  logic br_w;
  logic [DATA_BITS-1:0] data_out;
  logic busy;
  logic done;
  modport master (
    input start, abort, unlock_code, sdrd,
    output sser_n, ba13, ba12, ba_nib, br_w, data_out, busy, done
  );
  modport slave (
    output start, abort, unlock_code, sdrd,
    input sser_n, ba13, ba12, ba_nib, br_w, data_out, busy, done
  );
endinterface

// File: rtl/serial_key_reader.sv
// serial_key_reader: issues unlock accesses then reads DATA_BITS serial key bits into data_out
module serial_key_reader #(
  parameter int NUM_UNLOCK = 4,
  parameter int DATA_BITS = 16,
  parameter int STROBE_CYCLES = 2,
  parameter logic [3:0] READ_NIB = 4'h0
) (
  input logic clk,
  input logic rst,
  serial_key_reader_if.master bus
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, RECOVER, FINISH} state_t;
  state_t state;
  logic phase;
  logic [5:0] idx;
  logic [2:0] scnt;
  logic [4*NUM_UNLOCK-1:0] code;
  assign bus.ba13 = 1'b0;
  // bus outputs are loaded on entry to each state so they are registered and stable under sser_n
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      phase <= 1'b0;
      idx <= '0;
      scnt <= '0;
      code <= '0;
      bus.sser_n <= 1'b1;
      bus.ba12 <= 1'b0;
      bus.ba_nib <= 4'h0;
      bus.br_w <= 1'b0;
      bus.data_out <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else if (bus.abort) begin
      state <= IDLE;
      bus.sser_n <= 1'b1;
      bus.ba12 <= 1'b0;
      bus.ba_nib <= 4'h0;
      bus.br_w <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            code <= bus.unlock_code;
            bus.data_out <= '0;
            phase <= 1'b0;
            idx <= '0;
            bus.busy <= 1'b1;
            bus.ba12 <= 1'b1;
            bus.br_w <= 1'b1;
            bus.ba_nib <= bus.unlock_code[3:0];
            state <= SETUP;
          end
        end
        SETUP: begin
          bus.sser_n <= 1'b0;
          scnt <= '0;
          state <= STROBE;
        end
        STROBE: begin
          if (scnt == 3'(STROBE_CYCLES - 1)) begin
            bus.sser_n <= 1'b1;
            state <= RECOVER;
            if (phase) bus.data_out <= (bus.data_out << 1) | DATA_BITS'(bus.sdrd);
          end else begin
            scnt <= scnt + 3'd1;
          end
        end
        RECOVER: begin
          if (!phase && idx == 6'(NUM_UNLOCK - 1)) begin
            phase <= 1'b1;
            idx <= '0;
            bus.ba_nib <= READ_NIB;
            state <= SETUP;
          end else if (phase && idx == 6'(DATA_BITS - 1)) begin
            bus.ba12 <= 1'b0;
            bus.br_w <= 1'b0;
            bus.ba_nib <= 4'h0;
            state <= FINISH;
          end else begin
            idx <= idx + 6'd1;
            bus.ba_nib <= phase ? READ_NIB : code[4*(int'(idx)+1) +: 4];
            state <= SETUP;
          end
        end
        FINISH: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
